// File: rtl/st_pkg.sv
// Shared stack-op definitions: op_sel one-hot codes, issue step count and Thumb match patterns.
// Used by the stack sequencer and the stack controller.
package st_pkg;

    // One-hot stack operation codes carried on op_sel.
    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpPush  = 8'h01;
    localparam logic [7:0] OpPop   = 8'h02;
    localparam logic [7:0] OpAddsp = 8'h04;
    localparam logic [7:0] OpSubsp = 8'h08;
    localparam logic [7:0] OpMovsp = 8'h10;
    localparam logic [7:0] OpAdds  = 8'h20;
    localparam logic [7:0] OpLdrsp = 8'h40;
    localparam logic [7:0] OpStrsp = 8'h80;

    // PUSH/POP issue: header, 9 list positions, tail.
    localparam int unsigned StepCount = 11;
    localparam logic [3:0]  CntListLoad = 4'(StepCount - 1);

    // Thumb opcode match patterns: (instr & Mask) == Pat.
    localparam logic [15:0] PatPush   = 16'hB400;
    localparam logic [15:0] MaskPush  = 16'hFE00;
    localparam logic [15:0] PatPop    = 16'hBC00;
    localparam logic [15:0] MaskPop   = 16'hFE00;
    localparam logic [15:0] PatAddsp  = 16'hB000;
    localparam logic [15:0] MaskAddsp = 16'hFF80;
    localparam logic [15:0] PatSubsp  = 16'hB080;
    localparam logic [15:0] MaskSubsp = 16'hFF80;
    localparam logic [15:0] PatMovsp  = 16'h4668;
    localparam logic [15:0] MaskMovsp = 16'hFFF8;
    localparam logic [15:0] PatAdds   = 16'hA800;
    localparam logic [15:0] MaskAdds  = 16'hF800;
    localparam logic [15:0] PatLdrsp  = 16'h9800;
    localparam logic [15:0] MaskLdrsp = 16'hF800;
    localparam logic [15:0] PatStrsp  = 16'h9000;
    localparam logic [15:0] MaskStrsp = 16'hF800;

    typedef enum logic [0:0] {
        StIdle,
        StExec
    } st_state_e;

    function automatic logic pat_match(input logic [15:0] instr, input logic [15:0] pat,
                                       input logic [15:0] mask);
        return (instr & mask) == pat;
    endfunction

endpackage

// File: rtl/st_decode.sv
// Combinational Thumb stack-instruction decoder: instr -> op_sel and operand fields.
module st_decode
    import st_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [7:0]  op_sel_o,
    output logic [8:0]  rl_o,
    output logic [2:0]  rd0_o,
    output logic [2:0]  rd1_o,
    output logic [15:0] offset_o
);

    // Pattern match with all fields defaulting to zero (NOP).
    always_comb begin
        op_sel_o = OpNop;
        rl_o     = '0;
        rd0_o    = '0;
        rd1_o    = '0;
        offset_o = '0;
        if (pat_match(instr_i, PatPush, MaskPush)) begin
            op_sel_o = OpPush;
            rl_o     = instr_i[8:0];
        end else if (pat_match(instr_i, PatPop, MaskPop)) begin
            op_sel_o = OpPop;
            rl_o     = instr_i[8:0];
        end else if (pat_match(instr_i, PatAddsp, MaskAddsp)) begin
            op_sel_o = OpAddsp;
            offset_o = {7'b0, instr_i[6:0], 2'b00};
        end else if (pat_match(instr_i, PatSubsp, MaskSubsp)) begin
            op_sel_o = OpSubsp;
            offset_o = {7'b0, instr_i[6:0], 2'b00};
        end else if (pat_match(instr_i, PatMovsp, MaskMovsp)) begin
            op_sel_o = OpMovsp;
            rd0_o    = instr_i[2:0];
        end else if (pat_match(instr_i, PatAdds, MaskAdds)) begin
            op_sel_o = OpAdds;
            rd1_o    = instr_i[10:8];
            offset_o = {6'b0, instr_i[7:0], 2'b00};
        end else if (pat_match(instr_i, PatLdrsp, MaskLdrsp)) begin
            op_sel_o = OpLdrsp;
            rd1_o    = instr_i[10:8];
            offset_o = {6'b0, instr_i[7:0], 2'b00};
        end else if (pat_match(instr_i, PatStrsp, MaskStrsp)) begin
            op_sel_o = OpStrsp;
            rd1_o    = instr_i[10:8];
            offset_o = {6'b0, instr_i[7:0], 2'b00};
        end
    end

endmodule

// File: rtl/st_sequencer.sv
// Stack-op sequencer: accepts Thumb stack instructions and issues them step by step to the
// stack controller. Optional `illegal` output is enabled by defining ST_SEQ_ILLEGAL_EN.
module st_sequencer
    import st_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        st_hold,
    output logic [7:0]  op_sel,
    output logic [8:0]  RL,
    output logic [2:0]  Rd0,
    output logic [2:0]  Rd1,
    output logic [15:0] offset,
    output logic        ST_Wen,
    output logic        busy
`ifdef ST_SEQ_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    st_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  op_q, op_d;
    logic [8:0]  rl_q, rl_d;
    logic [2:0]  rd0_q, rd0_d;
    logic [2:0]  rd1_q, rd1_d;
    logic [15:0] off_q, off_d;

    logic [7:0]  dec_op;
    logic [8:0]  dec_rl;
    logic [2:0]  dec_rd0;
    logic [2:0]  dec_rd1;
    logic [15:0] dec_off;

    logic exec;
    logic step_done;
    logic accept;

    st_decode u_decode (
        .instr_i  (instr),
        .op_sel_o (dec_op),
        .rl_o     (dec_rl),
        .rd0_o    (dec_rd0),
        .rd1_o    (dec_rd1),
        .offset_o (dec_off)
    );

    // Handshake and outputs; fields are only visible while issuing.
    always_comb begin
        exec        = (state_q == StExec);
        ST_Wen      = exec && (op_q != OpNop) && !st_hold;
        // A NOP step completes regardless of st_hold.
        step_done   = exec && (ST_Wen || (op_q == OpNop));
        instr_ready = !exec || (step_done && (cnt_q == 4'd0));
        accept      = instr_valid && instr_ready;
        busy        = exec;
        op_sel      = exec ? op_q  : '0;
        RL          = exec ? rl_q  : '0;
        Rd0         = exec ? rd0_q : '0;
        Rd1         = exec ? rd1_q : '0;
        offset      = exec ? off_q : '0;
    end

`ifdef ST_SEQ_ILLEGAL_EN
    // Flag the single issue cycle of an undecodable instruction.
    always_comb begin
        illegal = exec && (op_q == OpNop);
    end
`endif

    // Next state: load on accept, otherwise count steps down and retire at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rl_d    = rl_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        off_d   = off_q;
        if (accept) begin
            state_d = StExec;
            op_d    = dec_op;
            rl_d    = dec_rl;
            rd0_d   = dec_rd0;
            rd1_d   = dec_rd1;
            off_d   = dec_off;
            cnt_d   = ((dec_op == OpPush) || (dec_op == OpPop)) ? CntListLoad : 4'd0;
        end else if (step_done) begin
            if (cnt_q == 4'd0) begin
                state_d = StIdle;
                op_d    = '0;
                rl_d    = '0;
                rd0_d   = '0;
                rd1_d   = '0;
                off_d   = '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // State and field registers; reset aborts any sequence in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            rl_q    <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rl_q    <= rl_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            off_q   <= off_d;
        end
    end

endmodule

// File: tb/tb_st_sequencer.sv
// Self-checking bench for st_sequencer: decode table, directed multi-cycle sequences and
// randomized traffic against a steps-remaining reference model.
module tb_st_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        st_hold;
    logic [7:0]  op_sel;
    logic [8:0]  RL;
    logic [2:0]  Rd0;
    logic [2:0]  Rd1;
    logic [15:0] offset;
    logic        ST_Wen;
    logic        busy;
`ifdef ST_SEQ_ILLEGAL_EN
    logic        illegal;
`endif

    st_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .st_hold     (st_hold),
        .op_sel      (op_sel),
        .RL          (RL),
        .Rd0         (Rd0),
        .Rd1         (Rd1),
        .offset      (offset),
        .ST_Wen      (ST_Wen),
        .busy        (busy)
`ifdef ST_SEQ_ILLEGAL_EN
        ,
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: whether an instruction is issuing, how many steps remain, its fields.
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [7:0]  m_op   = '0;
    logic [8:0]  m_rl   = '0;
    logic [2:0]  m_rd0  = '0;
    logic [2:0]  m_rd1  = '0;
    logic [15:0] m_off  = '0;
    logic        s_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [15:0] i, output logic [7:0] op,
                                       output logic [8:0] rl, output logic [2:0] rd0,
                                       output logic [2:0] rd1, output logic [15:0] off);
        op = 8'h00; rl = '0; rd0 = '0; rd1 = '0; off = '0;
        casez (i)
            16'b1011_010?_????_????: begin op = 8'h01; rl = i[8:0]; end
            16'b1011_110?_????_????: begin op = 8'h02; rl = i[8:0]; end
            16'b1011_0000_0???_????: begin op = 8'h04; off = 16'(i[6:0]) * 16'd4; end
            16'b1011_0000_1???_????: begin op = 8'h08; off = 16'(i[6:0]) * 16'd4; end
            16'b0100_0110_0110_1???: begin op = 8'h10; rd0 = i[2:0]; end
            16'b1010_1???_????_????: begin op = 8'h20; rd1 = i[10:8]; off = 16'(i[7:0]) * 16'd4; end
            16'b1001_1???_????_????: begin op = 8'h40; rd1 = i[10:8]; off = 16'(i[7:0]) * 16'd4; end
            16'b1001_0???_????_????: begin op = 8'h80; rd1 = i[10:8]; off = 16'(i[7:0]) * 16'd4; end
            default: ;
        endcase
    endfunction

    // One clock: drive inputs after the falling edge, compare against the model, advance it.
    task automatic cycle(input logic v, input logic [15:0] ins, input logic h);
        logic e_wen, done, e_ready, acc;
        @(negedge clk);
        instr_valid = v;
        instr       = ins;
        st_hold     = h;
        #1;
        e_wen   = m_busy && (m_op != 8'h00) && !h;
        done    = m_busy && ((m_op == 8'h00) || !h);
        e_ready = !m_busy || (done && (m_left == 1));
        acc     = v && e_ready;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("instr_ready", 32'(instr_ready), 32'(e_ready));
        chk("ST_Wen", 32'(ST_Wen), 32'(e_wen));
        chk("op_sel", 32'(op_sel), m_busy ? 32'(m_op) : 32'd0);
        chk("RL", 32'(RL), m_busy ? 32'(m_rl) : 32'd0);
        chk("Rd0", 32'(Rd0), m_busy ? 32'(m_rd0) : 32'd0);
        chk("Rd1", 32'(Rd1), m_busy ? 32'(m_rd1) : 32'd0);
        chk("offset", 32'(offset), m_busy ? 32'(m_off) : 32'd0);
`ifdef ST_SEQ_ILLEGAL_EN
        chk("illegal", 32'(illegal), 32'(m_busy && (m_op == 8'h00)));
`endif
        s_busy = busy;
        if (done) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
        if (acc) begin
            ref_decode(ins, m_op, m_rl, m_rd0, m_rd1, m_off);
            m_left = ((m_op == 8'h01) || (m_op == 8'h02)) ? 11 : 1;
            m_busy = 1'b1;
        end
    endtask

    // Assert reset between edges and check the outputs respond at once.
    task automatic apply_reset();
        @(negedge clk);
        resetn      = 1'b0;
        instr_valid = 1'b0;
        st_hold     = 1'b0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_outs", {op_sel, RL, Rd0, Rd1, 3'b0, ST_Wen, busy}, 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
        m_busy = 1'b0;
        m_left = 0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_busy; k++) cycle(1'b0, 16'h0, 1'b0);
        chk("drain_idle", 32'(m_busy), 32'd0);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  op;
        logic [8:0]  rl;
        logic [2:0]  rd0;
        logic [2:0]  rd1;
        logic [15:0] off;
        int          len;
    } vec_t;

    vec_t vecs[12];
    int   n;
    int   pick;
    logic [15:0] bases[8];
    logic [15:0] lows[8];
    logic [15:0] rins;

    initial begin
        vecs[0]  = '{16'hB505, 8'h01, 9'h105, 3'd0, 3'd0, 16'h0000, 11};
        vecs[1]  = '{16'hBD02, 8'h02, 9'h102, 3'd0, 3'd0, 16'h0000, 11};
        vecs[2]  = '{16'hB400, 8'h01, 9'h000, 3'd0, 3'd0, 16'h0000, 11};
        vecs[3]  = '{16'hB07F, 8'h04, 9'h000, 3'd0, 3'd0, 16'h01FC, 1};
        vecs[4]  = '{16'hB0FF, 8'h08, 9'h000, 3'd0, 3'd0, 16'h01FC, 1};
        vecs[5]  = '{16'h466C, 8'h10, 9'h000, 3'd4, 3'd0, 16'h0000, 1};
        vecs[6]  = '{16'hAFFF, 8'h20, 9'h000, 3'd0, 3'd7, 16'h03FC, 1};
        vecs[7]  = '{16'h9B02, 8'h40, 9'h000, 3'd0, 3'd3, 16'h0008, 1};
        vecs[8]  = '{16'h9001, 8'h80, 9'h000, 3'd0, 3'd0, 16'h0004, 1};
        vecs[9]  = '{16'h4600, 8'h00, 9'h000, 3'd0, 3'd0, 16'h0000, 1};
        vecs[10] = '{16'hFFFF, 8'h00, 9'h000, 3'd0, 3'd0, 16'h0000, 1};
        vecs[11] = '{16'hB580, 8'h01, 9'h180, 3'd0, 3'd0, 16'h0000, 11};
        bases = '{16'hB400, 16'hBC00, 16'hB000, 16'hB080, 16'h4668, 16'hA800, 16'h9800, 16'h9000};
        lows  = '{16'h01FF, 16'h01FF, 16'h007F, 16'h007F, 16'h0007, 16'h07FF, 16'h07FF, 16'h07FF};

        resetn = 1'b0; instr_valid = 1'b0; instr = '0; st_hold = 1'b0;
        #1;
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_op", 32'(op_sel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Decode table: each instruction issued alone from idle.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].ins, 1'b0);
            cycle(1'b0, 16'h0, 1'b0);
            chk("tbl_op", 32'(op_sel), 32'(vecs[i].op));
            chk("tbl_rl", 32'(RL), 32'(vecs[i].rl));
            chk("tbl_rd0", 32'(Rd0), 32'(vecs[i].rd0));
            chk("tbl_rd1", 32'(Rd1), 32'(vecs[i].rd1));
            chk("tbl_off", 32'(offset), 32'(vecs[i].off));
            n = 0;
            for (int k = 0; k < 40 && s_busy; k++) begin
                n++;
                cycle(1'b0, 16'h0, 1'b0);
            end
            chk("tbl_len", 32'(n), 32'(vecs[i].len));
        end

        // PUSH {R0,R2,LR}: ready low on cycles 1-10, ready on the tail.
        cycle(1'b1, 16'hB505, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            cycle(1'b1, 16'h0000, 1'b0);
            chk("push_wen", 32'(ST_Wen), 32'd1);
            chk("push_ready", 32'(instr_ready), (k == 11) ? 32'd1 : 32'd0);
        end
        drain();

        // LDR then back-to-back SUB SP.
        cycle(1'b1, 16'h9B02, 1'b0);
        cycle(1'b1, 16'hB084, 1'b0);
        chk("ldr_op", 32'(op_sel), 32'h40);
        chk("ldr_off", 32'(offset), 32'h8);
        cycle(1'b0, 16'h0, 1'b0);
        chk("sub_op", 32'(op_sel), 32'h08);
        chk("sub_off", 32'(offset), 32'h10);
        drain();

        // POP {R1,PC} with hold on steps 3-5 stretches issue to 14 cycles.
        cycle(1'b1, 16'hBD02, 1'b0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b0, 16'h0, (k >= 3) && (k <= 5));
            if (!s_busy) break;
            n++;
            chk("pop_op", 32'(op_sel), 32'h02);
        end
        chk("pop_len", 32'(n), 32'd14);

        // Undecodable word under hold still takes exactly one cycle.
        cycle(1'b1, 16'h0000, 1'b0);
        cycle(1'b0, 16'h0, 1'b1);
        chk("nop_busy", 32'(busy), 32'd1);
        chk("nop_wen", 32'(ST_Wen), 32'd0);
        cycle(1'b0, 16'h0, 1'b1);
        chk("nop_done", 32'(busy), 32'd0);

        // Reset at step 5 of a PUSH, then MOV R4,SP.
        cycle(1'b1, 16'hB505, 1'b0);
        for (int k = 1; k <= 4; k++) cycle(1'b0, 16'h0, 1'b0);
        apply_reset();
        cycle(1'b1, 16'h466C, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        chk("mov_op", 32'(op_sel), 32'h10);
        chk("mov_rd0", 32'(Rd0), 32'd4);
        drain();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            pick = int'($urandom_range(0, 8));
            if (pick == 8) rins = 16'($urandom);
            else rins = bases[pick] | (16'($urandom) & lows[pick]);
            cycle(1'($urandom_range(0, 1)), rins, $urandom_range(0, 9) < 3);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
